// File: rtl/alu_pkg.sv
// Shared ALU op codes and exec-stage FSM state type.
package alu_pkg;
  localparam logic [2:0] AOP_AND = 3'b000;
  localparam logic [2:0] AOP_OR  = 3'b001;
  localparam logic [2:0] AOP_XOR = 3'b010;
  localparam logic [2:0] SUB     = 3'b101;
  localparam logic [2:0] ADD_C   = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/alu_exec_fsm.sv
// Control for the exec stage: IDLE -> EXEC (one cycle) -> DONE, handshake strobes.
module alu_exec_fsm
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic accept,
  output logic capture
);
  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/alu_exec_stage.sv
// Registered operand/result wrapper around an external ALU, with carry chaining,
// sticky overflow and a completed-op counter.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_aop,
  input  logic             in_cin,
  input  logic             in_chain,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_aop,
  output logic             alu_cin,
  input  logic [N-1:0]     alu_out,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_cout,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);
  logic accept, capture, carry_reg;

  alu_exec_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .accept    (accept),
    .capture   (capture)
  );

  // Operands go to the ALU only through these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_aop <= '0;
      alu_cin <= 1'b0;
    end else if (accept) begin
      alu_a   <= in_a;
      alu_b   <= in_b;
      alu_aop <= in_aop;
      alu_cin <= in_chain ? carry_reg : in_cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_cout   <= 1'b0;
      carry_reg  <= 1'b0;
      op_count   <= '0;
    end else if (capture) begin
      out_result <= alu_out;
      out_zero   <= alu_zero;
      out_ovf    <= alu_ovf;
      out_cout   <= alu_cout;
      carry_reg  <= alu_cout;
      op_count   <= op_count + CNT_W'(1);
    end
  end

  // A capture takes priority over a concurrent clear so no overflow is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             sticky_ovf <= 1'b0;
    else if (capture)    sticky_ovf <= sticky_ovf | alu_ovf;
    else if (clr_sticky) sticky_ovf <= 1'b0;
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural ALU attached.
module tb_alu_exec_stage;
  import alu_pkg::*;
  localparam int N = 32;
  localparam int CNT_W = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_cin = 1'b0, in_chain = 1'b0;
  logic out_ready = 1'b0, clr_sticky = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic [2:0] in_aop = '0;
  logic in_ready, out_valid, out_zero, out_ovf, out_cout, sticky_ovf, alu_cin;
  logic [N-1:0] alu_a, alu_b, alu_out, out_result;
  logic [2:0] alu_aop;
  logic alu_zero, alu_ovf, alu_cout;
  logic [CNT_W-1:0] op_count;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_aop(in_aop), .in_cin(in_cin), .in_chain(in_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aop(alu_aop), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_cout(out_cout),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count)
  );

  // Behavioural ALU: subtract forces carry-in of 1 via a + ~b + 1.
  logic [N:0] sum;
  logic [N-1:0] bb;
  always_comb begin
    bb = (alu_aop == SUB) ? ~alu_b : alu_b;
    sum = '0;
    alu_out = '0;
    alu_cout = 1'b0;
    alu_ovf = 1'b0;
    case (alu_aop)
      ADD_C, SUB: begin
        sum = {1'b0, alu_a} + {1'b0, bb} + ((alu_aop == SUB) ? (N+1)'(1) : (N+1)'(alu_cin));
        alu_out = sum[N-1:0];
        alu_cout = sum[N];
        alu_ovf = (alu_a[N-1] == bb[N-1]) && (sum[N-1] != alu_a[N-1]);
      end
      AOP_AND: alu_out = alu_a & alu_b;
      AOP_OR:  alu_out = alu_a | alu_b;
      AOP_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a;
    endcase
    alu_zero = (alu_out == '0);
  end

  // Present an op at a negedge, take the accept edge, return at next negedge (state EXEC).
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] aop,
                       input logic cin, input logic chain);
    in_a = a; in_b = b; in_aop = aop; in_cin = cin; in_chain = chain; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_chain = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    total++;
    if (!out_valid) $display("FAIL wait_done: out_valid=%0b after %0d cycles, required 1", out_valid, n);
    else pass_cnt++;
  endtask

  task automatic retire();
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #12;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_hs: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid); else pass_cnt++;
    total++; if (alu_a !== '0 || alu_b !== '0 || alu_aop !== 3'd0 || alu_cin !== 1'b0) $display("FAIL reset_alu: a=%h b=%h aop=%0d cin=%0b, required 0", alu_a, alu_b, alu_aop, alu_cin); else pass_cnt++;
    total++; if (out_result !== '0 || sticky_ovf !== 1'b0 || op_count !== '0) $display("FAIL reset_out: res=%h sticky=%0b cnt=%0d, required 0", out_result, sticky_ovf, op_count); else pass_cnt++;
    @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_add();
    issue(32'd5, 32'd7, ADD_C, 1'b0, 1'b0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) $display("FAIL add_exec: out_valid=%0b in_ready=%0b a=%0d b=%0d, required 0/0/5/7", out_valid, in_ready, alu_a, alu_b); else pass_cnt++;
    @(negedge clk); @(negedge clk);  // after k+2
    total++; if (out_valid !== 1'b1 || out_result !== 32'd12 || out_zero !== 1'b0) $display("FAIL add_result: valid=%0b res=%0d zero=%0b, required 1/12/0", out_valid, out_result, out_zero); else pass_cnt++;
    total++; if (op_count !== 16'd1) $display("FAIL add_count: op_count=%0d, required 1", op_count); else pass_cnt++;
    retire();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL add_retire: in_ready=%0b out_valid=%0b, required 1/0", in_ready, out_valid); else pass_cnt++;
  endtask

  task automatic test_sub();
    issue(32'h1234, 32'h1234, SUB, 1'b0, 1'b0);
    wait_done();
    total++; if (out_result !== 32'd0 || out_zero !== 1'b1 || out_cout !== 1'b1) $display("FAIL sub_zero: res=%h zero=%0b cout=%0b, required 0/1/1", out_result, out_zero, out_cout); else pass_cnt++;
    retire();
  endtask

  task automatic test_chain();
    issue(32'hFFFF_FFFF, 32'd1, ADD_C, 1'b0, 1'b0);
    wait_done();
    total++; if (out_result !== 32'd0 || out_cout !== 1'b1) $display("FAIL chain_first: res=%h cout=%0b, required 0/1", out_result, out_cout); else pass_cnt++;
    retire();
    issue(32'd0, 32'd0, ADD_C, 1'b0, 1'b1);
    total++; if (alu_cin !== 1'b1) $display("FAIL chain_cin: alu_cin=%0b, required 1", alu_cin); else pass_cnt++;
    wait_done();
    total++; if (out_result !== 32'd1 || op_count !== 16'd4) $display("FAIL chain_result: res=%h cnt=%0d, required 1/4", out_result, op_count); else pass_cnt++;
    retire();
  endtask

  task automatic test_back_to_back();
    issue(32'd3, 32'd4, ADD_C, 1'b0, 1'b0);
    wait_done();
    in_a = 32'hDEAD; in_b = 32'hBEEF; in_aop = AOP_XOR; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'd7 || alu_a !== 32'd3)
        $display("FAIL stall_%0d: in_ready=%0b valid=%0b res=%0d alu_a=%0d, required 0/1/7/3", i, in_ready, out_valid, out_result, alu_a);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    retire();
    total++; if (op_count !== 16'd5) $display("FAIL stall_count: op_count=%0d, required 5", op_count); else pass_cnt++;
  endtask

  task automatic test_sticky();
    issue(32'h7FFF_FFFF, 32'd1, ADD_C, 1'b0, 1'b0);
    clr_sticky = 1'b1;  // high on the capture edge
    @(negedge clk); clr_sticky = 1'b0;
    total++; if (sticky_ovf !== 1'b1 || out_ovf !== 1'b1 || out_result !== 32'h8000_0000) $display("FAIL sticky_set: sticky=%0b ovf=%0b res=%h, required 1/1/80000000", sticky_ovf, out_ovf, out_result); else pass_cnt++;
    retire();
    issue(32'd1, 32'd1, ADD_C, 1'b0, 1'b0);
    wait_done();
    total++; if (sticky_ovf !== 1'b1) $display("FAIL sticky_hold: sticky=%0b, required 1", sticky_ovf); else pass_cnt++;
    retire();
    clr_sticky = 1'b1; @(negedge clk); clr_sticky = 1'b0;
    total++; if (sticky_ovf !== 1'b0) $display("FAIL sticky_clr: sticky=%0b, required 0", sticky_ovf); else pass_cnt++;
  endtask

  task automatic test_reset_exec();
    issue(32'hFFFF_FFFF, 32'd1, ADD_C, 1'b0, 1'b0);  // leaves carry_reg=1
    wait_done();
    total++; if (op_count !== 16'd8) $display("FAIL pre_rst_count: op_count=%0d, required 8", op_count); else pass_cnt++;
    retire();
    issue(32'd9, 32'd9, ADD_C, 1'b0, 1'b0);
    #2 rst = 1'b1; #2;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_exec: out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready); else pass_cnt++;
    @(negedge clk); rst = 1'b0; @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_count !== 16'd0) $display("FAIL rst_release: valid=%0b ready=%0b cnt=%0d, required 0/1/0", out_valid, in_ready, op_count); else pass_cnt++;
    issue(32'd0, 32'd0, ADD_C, 1'b1, 1'b1);  // chained: cin must come from cleared carry_reg
    total++; if (alu_cin !== 1'b0) $display("FAIL rst_carry: alu_cin=%0b, required 0", alu_cin); else pass_cnt++;
    wait_done();
    total++; if (out_result !== 32'd0 || op_count !== 16'd1) $display("FAIL rst_after: res=%h cnt=%0d, required 0/1", out_result, op_count); else pass_cnt++;
    retire();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_chain();
    test_back_to_back();
    test_sticky();
    test_reset_exec();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
